// File: rtl/even_odd_pkg.sv
// Shared types for the even/odd up/down counter sequence checker.
package even_odd_pkg;

    localparam int unsigned ValW = 4;

    typedef logic [ValW-1:0] val_t;

    typedef enum logic [1:0] {
        StEmpty,
        StRef,
        StLockUp,
        StLockDown
    } state_e;

    typedef enum logic [1:0] {
        StepUp,
        StepDown,
        StepBad
    } step_e;

endpackage

// File: rtl/even_odd_seq_checker_if.sv
// Sample stream in, checker status out; clk/rst stay plain ports on the modules.
interface even_odd_seq_checker_if
    import even_odd_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
);

    logic                 sample_valid;
    val_t                 sample_data;
    logic                 locked;
    logic                 dir_up;
    logic                 dir_change;
    logic                 seq_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output sample_valid,
        output sample_data,
        input  locked,
        input  dir_up,
        input  dir_change,
        input  seq_err,
        input  err_count
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output locked,
        output dir_up,
        output dir_change,
        output seq_err,
        output err_count
    );

endinterface

// File: rtl/even_odd_step_classify.sv
// Classifies one step ref_val -> sample as a legal up step, a legal down step, or bad.
module even_odd_step_classify
    import even_odd_pkg::*;
(
    input  val_t  ref_val,
    input  val_t  sample,
    output step_e step
);

    val_t up_succ;
    val_t down_succ;

    always_comb begin
        // Odd values step by one to the next even, evens by two; arithmetic wraps mod 16.
        up_succ = ref_val[0] ? ref_val + val_t'(1) : ref_val + val_t'(2);

        if (ref_val[0]) begin
            down_succ = ref_val - val_t'(2);
        end else if (ref_val == '0) begin
            down_succ = '0;
        end else begin
            down_succ = ref_val - val_t'(1);
        end

        if (sample == up_succ) begin
            step = StepUp;
        end else if (sample == down_succ) begin
            step = StepDown;
        end else begin
            step = StepBad;
        end
    end

endmodule

// File: rtl/even_odd_seq_checker.sv
// Tracks an even/odd up/down counter and flags illegal steps and direction reversals.
// Define EVEN_ODD_CHK_ERR_COUNT_EN to build the saturating error counter; otherwise err_count is 0.
module even_odd_seq_checker
    import even_odd_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic                     clk,
    input logic                     rst,
    even_odd_seq_checker_if.slave   bus
);

    state_e state_q, state_d;
    val_t   ref_q, ref_d;
    logic   dir_up_q, dir_up_d;
    logic   dir_change_q, dir_change_d;
    logic   seq_err_q, seq_err_d;
    step_e  step;

    even_odd_step_classify u_classify (
        .ref_val (ref_q),
        .sample  (bus.sample_data),
        .step    (step)
    );

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        dir_up_d     = dir_up_q;
        dir_change_d = 1'b0;
        seq_err_d    = 1'b0;

        if (bus.sample_valid) begin
            // Every accepted sample becomes the new reference, legal or not.
            ref_d = bus.sample_data;
            if (state_q == StEmpty) begin
                state_d = StRef;
            end else begin
                unique case (step)
                    StepUp: begin
                        state_d      = StLockUp;
                        dir_up_d     = 1'b1;
                        dir_change_d = (state_q == StLockDown);
                    end
                    StepDown: begin
                        state_d      = StLockDown;
                        dir_up_d     = 1'b0;
                        dir_change_d = (state_q == StLockUp);
                    end
                    default: begin
                        state_d   = StRef;
                        seq_err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            ref_q        <= '0;
            dir_up_q     <= 1'b0;
            dir_change_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            dir_up_q     <= dir_up_d;
            dir_change_q <= dir_change_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign bus.locked     = (state_q == StLockUp) || (state_q == StLockDown);
    assign bus.dir_up     = dir_up_q;
    assign bus.dir_change = dir_change_q;
    assign bus.seq_err    = seq_err_q;

`ifdef EVEN_ODD_CHK_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (seq_err_d && (err_count_q != '1)) begin
            err_count_q <= err_count_q + ERR_CNT_W'(1);
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_even_odd_seq_checker.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and compares each cycle.
// Expected err_count follows EVEN_ODD_CHK_ERR_COUNT_EN, so the bench suits either build.
module tb_even_odd_seq_checker;

    localparam int unsigned CntW = 2;
    localparam int CntMax = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    even_odd_seq_checker_if #(.ERR_CNT_W(CntW)) bus ();

    even_odd_seq_checker #(.ERR_CNT_W(CntW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit locked;
        bit dir_up;
        bit dir_change;
        bit seq_err;
        int err_count;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: what the spec says, in terms of "have a reference / locked / direction".
    bit m_have_ref;
    bit m_locked;
    bit m_dir;
    int m_ref;
    int m_cnt;

    function automatic int up_of(int x);
        return (x % 2 == 0) ? (x + 2) % 16 : (x + 1) % 16;
    endfunction

    function automatic int down_of(int x);
        if (x % 2 == 1) return (x + 14) % 16;
        if (x == 0) return 0;
        return x - 1;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit v, int d);
        exp_t e;
        bit nd;
        @(negedge clk);
        rst              = r;
        bus.sample_valid = v;
        bus.sample_data  = 4'(d);
        e.dir_change = 1'b0;
        e.seq_err    = 1'b0;
        if (r) begin
            m_have_ref = 1'b0;
            m_ref      = 0;
            m_locked   = 1'b0;
            m_dir      = 1'b0;
            m_cnt      = 0;
        end else if (v) begin
            if (!m_have_ref) begin
                m_have_ref = 1'b1;
            end else if (d == up_of(m_ref) || d == down_of(m_ref)) begin
                nd           = (d == up_of(m_ref));
                e.dir_change = m_locked && (nd != m_dir);
                m_locked     = 1'b1;
                m_dir        = nd;
            end else begin
                e.seq_err = 1'b1;
                m_locked  = 1'b0;
`ifdef EVEN_ODD_CHK_ERR_COUNT_EN
                if (m_cnt < CntMax) m_cnt++;
`endif
            end
            m_ref = d;
        end
        e.locked    = m_locked;
        e.dir_up    = m_dir;
        e.err_count = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic samples(int a, int b, int c, int n);
        if (n > 0) step(1'b0, 1'b1, a);
        if (n > 1) step(1'b0, 1'b1, b);
        if (n > 2) step(1'b0, 1'b1, c);
    endtask

    // Monitor: outputs for the edge after a push are sampled 1 time unit past that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("locked",     8'(bus.locked),     8'(e.locked));
                check("dir_up",     8'(bus.dir_up),     8'(e.dir_up));
                check("dir_change", 8'(bus.dir_change), 8'(e.dir_change));
                check("seq_err",    8'(bus.seq_err),    8'(e.seq_err));
                check("err_count",  8'(bus.err_count),  8'(e.err_count));
            end
        end
    end

    initial begin
        int k;
        int d;
        bit r;
        bit v;
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        m_have_ref = 1'b0;
        m_locked   = 1'b0;
        m_dir      = 1'b0;
        m_ref      = 0;
        m_cnt      = 0;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 5);
        samples(0, 2, 4, 3);
        samples(6, 0, 0, 1);
        step(1'b0, 1'b0, 9);
        samples(14, 0, 2, 3);
        samples(1, 15, 13, 3);
        samples(4, 6, 5, 3);
        samples(3, 0, 0, 1);
        samples(0, 0, 0, 3);
        samples(7, 0, 0, 1);
        // Five more bad steps drive the 2-bit counter into saturation.
        samples(0, 9, 3, 3);
        samples(12, 1, 0, 2);
        samples(2, 4, 0, 2);
        step(1'b1, 1'b1, 5);
        samples(8, 10, 0, 2);

        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            if (k < 4) d = up_of(m_ref);
            else if (k < 8) d = down_of(m_ref);
            else d = $urandom_range(0, 15);
            step(r, v, d);
        end

        step(1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        check("drain", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/even_odd_seq_checker.md
EVEN_ODD_SEQ_CHECKER -- requirements
Module: even_odd_seq_checker

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sample_valid  input  1  sample_data is a new counter output this cycle.
REQ-005 sample_data  input  4  observed even/odd up/down counter value.
REQ-006 locked  output  1  direction established; dir_up is meaningful.
REQ-007 dir_up  output  1  1 = last legal step was up, 0 = down.
REQ-008 dir_change  output  1  one-cycle pulse: legal step reversed the locked direction.
REQ-009 seq_err  output  1  one-cycle pulse: step matched neither legal successor.
REQ-010 err_count  output  ERR_CNT_W  saturating count of seq_err pulses.

Function
REQ-011 Legal up successor of x: x+2 if x even, x+1 if x odd, modulo 16 (14->0, 15->0).
REQ-012 Legal down successor of x: x-2 mod 16 if x odd (1->15); x-1 if x even and nonzero; 0 if x==0 (hold).
REQ-013 Up and down successors of any x differ, so each step classifies uniquely as UP, DOWN or BAD.
REQ-014 States: EMPTY (no reference), REF (reference held, direction unknown), LOCK_UP, LOCK_DOWN.
REQ-015 Only cycles with sample_valid=1 change state or registers, except reset; idle cycles hold everything and outputs pulse low.
REQ-016 EMPTY + valid: store sample as reference -> REF; no pulses.
REQ-017 REF/LOCK_* + valid + UP: reference<=sample -> LOCK_UP; DOWN: reference<=sample -> LOCK_DOWN.
REQ-018 dir_change=1 in the cycle after a legal step from LOCK_UP to LOCK_DOWN or the reverse; never from REF.
REQ-019 BAD step (includes external loads): seq_err=1 next cycle, reference<=sample, state -> REF, locked=0.
REQ-020 Latency: all outputs registered; effect of a sample visible exactly one cycle after its valid cycle.
REQ-021 locked=1 only in LOCK_UP/LOCK_DOWN; dir_up holds last value while in REF/EMPTY.
REQ-022 err_count increments by 1 per seq_err, saturates at all-ones, never wraps.
REQ-023 dir_change and seq_err are mutually exclusive in any cycle.

Reset
REQ-024 rst=1 at a clock edge: state EMPTY, reference 0, locked 0, dir_up 0, dir_change 0, seq_err 0, err_count 0.
REQ-025 rst has priority over sample_valid; a sample in a reset cycle is discarded.
REQ-026 Reset mid-lock: next valid sample re-enters EMPTY->REF path; no error reported for the discontinuity.

Configuration
REQ-027 Macro EVEN_ODD_CHK_ERR_COUNT_EN defined: err_count implemented per REQ-022.
REQ-028 Macro undefined: err_count tied to 0, counter logic absent; seq_err unaffected.

Structure
REQ-029 Shared package even_odd_pkg: state enumeration, step classification enum (UP/DOWN/BAD), 4-bit value width constant.
REQ-030 One combinational sub-module even_odd_step_classify: inputs reference and sample, output step class.
REQ-031 Successor rules in REQ-011/012 live only in even_odd_step_classify.

Verification
REQ-032 Reset, valid samples 0,2,4,6 -> locked=1 after 2nd sample, dir_up=1, no seq_err.
REQ-033 Samples 14,0,2 -> legal wrap, locked up, no seq_err; samples 1,15,13 -> locked down, dir_up=0.
REQ-034 Samples 4,6,5,3 -> dir_change pulse exactly once one cycle after sample 5; dir_up=0.
REQ-035 Samples 0,0,0 -> LOCK_DOWN (zero hold legal), no seq_err; then 7 -> seq_err pulse, locked=0, err_count=1.
REQ-036 With macro, ERR_CNT_W=2, five BAD steps -> err_count saturates at 3; without macro err_count stays 0.
REQ-037 rst asserted while LOCK_UP with sample_valid=1 -> all outputs reset next cycle, sample ignored, next sample gives no seq_err.
